// File: rtl/rs_issue.sv
// -----------------------------------------------------------------------------
// rs_issue
// Single-entry issue stage that sits between a reservation station (RS) and
// one functional unit (FU). It takes the RS head entry into a hold register,
// waits until both source operands are resolved by common data bus (CDB)
// broadcasts, then presents the entry to the FU until it is accepted. A branch
// mispredict flushes the held entry (and blocks a capture) when its tag is at
// or above the flush threshold.
//
// Ports
//   clk           system clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   head_valid    RS not empty, head_element meaningful
//   head_element  RS head entry (tag 142:111, flag_a 104, data_a 103:72,
//                 flag_b 71, data_b 70:39)
//   pop           one-cycle request to advance the RS read pointer
//   cdb_valid     CDB broadcast valid
//   cdb_tag       producer tag on the CDB
//   cdb_data      result value on the CDB
//   branch        mispredict flush, sampled each cycle
//   branch_tag    flush threshold (kill when entry tag >= branch_tag)
//   fu_valid      issued entry valid to the FU
//   fu_ready      FU accepts the entry
//   fu_entry      held entry with resolved operands
//   busy          state is not IDLE
//   issue_count   completed FU handshakes, wraps modulo 2^16
// -----------------------------------------------------------------------------
module rs_issue #(
    parameter int DATA_WIDTH = 144,
    parameter int TAG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  head_valid,
    input  logic [DATA_WIDTH-1:0] head_element,
    output logic                  pop,
    input  logic                  cdb_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic [31:0]           cdb_data,
    input  logic                  branch,
    input  logic [TAG_WIDTH-1:0]  branch_tag,
    output logic                  fu_valid,
    input  logic                  fu_ready,
    output logic [DATA_WIDTH-1:0] fu_entry,
    output logic                  busy,
    output logic [15:0]           issue_count
);

    // Entry field positions
    localparam int TAG_HI = 142;
    localparam int TAG_LO = 111;
    localparam int FA_BIT = 104;
    localparam int DA_HI  = 103;
    localparam int DA_LO  = 72;
    localparam int FB_BIT = 71;
    localparam int DB_HI  = 70;
    localparam int DB_LO  = 39;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    // An operand still waiting (flag=0) carries its producer tag in the data
    // field; a matching broadcast replaces it with the value and sets the flag.
    // Both operands are checked independently so one broadcast can wake both.
    function automatic logic [DATA_WIDTH-1:0] cdb_resolve(
        input logic [DATA_WIDTH-1:0] entry,
        input logic                  bus_valid,
        input logic [TAG_WIDTH-1:0]  bus_tag,
        input logic [31:0]           bus_data
    );
        logic [DATA_WIDTH-1:0] res;
        logic                  hit_a;
        logic                  hit_b;
        res   = entry;
        hit_a = bus_valid && !entry[FA_BIT] && (entry[DA_HI:DA_LO] == 32'(bus_tag));
        hit_b = bus_valid && !entry[FB_BIT] && (entry[DB_HI:DB_LO] == 32'(bus_tag));
        res[FA_BIT]      = hit_a ? 1'b1     : entry[FA_BIT];
        res[DA_HI:DA_LO] = hit_a ? bus_data : entry[DA_HI:DA_LO];
        res[FB_BIT]      = hit_b ? 1'b1     : entry[FB_BIT];
        res[DB_HI:DB_LO] = hit_b ? bus_data : entry[DB_HI:DB_LO];
        return res;
    endfunction

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_pop;
    logic                  r_fu_valid;
    logic                  r_busy;
    logic [15:0]           r_issue_count;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_hold_nxt;
    logic                  w_pop_nxt;
    logic [15:0]           w_count_nxt;

    logic [DATA_WIDTH-1:0] w_head_fwd;
    logic [DATA_WIDTH-1:0] w_hold_snoop;
    logic [TAG_WIDTH-1:0]  w_head_tag;
    logic [TAG_WIDTH-1:0]  w_hold_tag;
    logic                  w_head_kill;
    logic                  w_hold_kill;
    logic                  w_handshake;

    assign w_head_fwd   = cdb_resolve(head_element, cdb_valid, cdb_tag, cdb_data);
    assign w_hold_snoop = cdb_resolve(r_hold, cdb_valid, cdb_tag, cdb_data);
    assign w_head_tag   = TAG_WIDTH'(head_element[TAG_HI:TAG_LO]);
    assign w_hold_tag   = TAG_WIDTH'(r_hold[TAG_HI:TAG_LO]);
    assign w_head_kill  = branch && (w_head_tag >= branch_tag);
    assign w_hold_kill  = branch && (w_hold_tag >= branch_tag);
    assign w_handshake  = r_fu_valid && fu_ready;

    // Next-state logic; priority is kill, then handshake, then capture, then snoop
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_pop_nxt   = 1'b0;
        w_count_nxt = r_issue_count;
        case (r_state)
            ST_IDLE: begin
                // Any branch in IDLE suppresses the capture
                if (head_valid && !branch) begin
                    w_hold_nxt  = w_head_fwd;
                    w_state_nxt = ST_WAIT;
                    w_pop_nxt   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_hold_kill) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_nxt = w_hold_snoop;
                    // Readiness uses the post-snoop flags so a resolving
                    // broadcast and the move to ISSUE share one edge
                    if (w_hold_snoop[FA_BIT] && w_hold_snoop[FB_BIT]) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_hold_kill) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_handshake) begin
                    w_count_nxt = r_issue_count + 16'd1;
                    if (head_valid && !w_head_kill) begin
                        w_hold_nxt  = w_head_fwd;
                        w_state_nxt = ST_WAIT;
                        w_pop_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, hold register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_hold        <= {DATA_WIDTH{1'b0}};
            r_pop         <= 1'b0;
            r_fu_valid    <= 1'b0;
            r_busy        <= 1'b0;
            r_issue_count <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_hold        <= w_hold_nxt;
            r_pop         <= w_pop_nxt;
            r_fu_valid    <= (w_state_nxt == ST_ISSUE);
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_issue_count <= w_count_nxt;
        end
    end

    assign pop         = r_pop;
    assign fu_valid    = r_fu_valid;
    assign fu_entry    = r_hold;
    assign busy        = r_busy;
    assign issue_count = r_issue_count;

endmodule

// File: tb/tb_rs_issue.sv
// -----------------------------------------------------------------------------
// tb_rs_issue
// Self-checking bench for rs_issue. Table vectors run single transactions
// through the block; hand-written sequences cover flush, back-to-back issue,
// reset mid-flight and counter wrap. Expected FU entries are queued when a
// head is driven and compared when the FU handshake happens.
// -----------------------------------------------------------------------------
module tb_rs_issue;

    localparam int DW = 144;
    localparam int TW = 32;

    logic          clk;
    logic          rst;
    logic          head_valid;
    logic [DW-1:0] head_element;
    logic          pop;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_data;
    logic          branch;
    logic [TW-1:0] branch_tag;
    logic          fu_valid;
    logic          fu_ready;
    logic [DW-1:0] fu_entry;
    logic          busy;
    logic [15:0]   issue_count;

    int            n_cmp;
    int            n_mis;
    logic [15:0]   exp_cnt;
    logic          prev_pop;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [31:0] tag;
        logic        fa;
        logic [31:0] da;
        logic        fb;
        logic [31:0] db;
        int          cdb_dly;   // -1: no broadcast, 0: at capture, k: k cycles after
        logic [31:0] ctag;
        logic [31:0] cdata;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vt[5];

    rs_issue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .head_valid   (head_valid),
        .head_element (head_element),
        .pop          (pop),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .branch       (branch),
        .branch_tag   (branch_tag),
        .fu_valid     (fu_valid),
        .fu_ready     (fu_ready),
        .fu_entry     (fu_entry),
        .busy         (busy),
        .issue_count  (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic [31:0] tag, input logic fa,
                                         input logic [31:0] da, input logic fb,
                                         input logic [31:0] db);
        logic [DW-1:0] e;
        e = {DW{1'b0}};
        e[142:111] = tag;
        e[104]     = fa;
        e[103:72]  = da;
        e[71]      = fb;
        e[70:39]   = db;
        return e;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Handshake scoreboard and pop spacing monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (pop) chk("pop_not_consecutive", {{(DW-1){1'b0}}, prev_pop}, {DW{1'b0}});
            if (fu_valid && fu_ready && !(branch && (fu_entry[142:111] >= branch_tag))) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL scoreboard_underflow: got handshake %0h expected none", fu_entry);
                end else begin
                    chk("fu_entry", fu_entry, exp_q.pop_front());
                end
            end
        end
        prev_pop <= pop;
    end

    task automatic run_vec(input vec_t v, input int idx);
        int cur;
        int rdy;
        @(posedge clk); #1;
        head_valid   = 1'b1;
        head_element = mk(v.tag, v.fa, v.da, v.fb, v.db);
        if (v.cdb_dly == 0) begin
            cdb_valid = 1'b1; cdb_tag = v.ctag; cdb_data = v.cdata;
        end
        exp_q.push_back(mk(v.tag, 1'b1, v.exp_a, 1'b1, v.exp_b));
        @(posedge clk); #1;
        head_valid   = 1'b0;
        head_element = {DW{1'b0}};
        cdb_valid    = 1'b0;
        cur = 1;
        rdy = (v.cdb_dly > 0) ? v.cdb_dly + 1 : 2;
        @(negedge clk);
        chk($sformatf("v%0d_pop", idx), pop, 1);
        chk($sformatf("v%0d_wait_fu_valid", idx), fu_valid, 0);
        while (cur < rdy) begin
            if (cur == v.cdb_dly) begin
                cdb_valid = 1'b1; cdb_tag = v.ctag; cdb_data = v.cdata;
            end
            @(posedge clk); #1;
            cdb_valid = 1'b0;
            cur++;
            @(negedge clk);
            if (cur < rdy) chk($sformatf("v%0d_early_fu_valid", idx), fu_valid, 0);
        end
        chk($sformatf("v%0d_latency_fu_valid", idx), fu_valid, 1);
        chk($sformatf("v%0d_busy", idx), busy, 1);
        @(posedge clk);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        chk($sformatf("v%0d_issue_count", idx), issue_count, exp_cnt);
        chk($sformatf("v%0d_idle_fu_valid", idx), fu_valid, 0);
        chk($sformatf("v%0d_idle_busy", idx), busy, 0);
    endtask

    initial begin
        n_cmp = 0; n_mis = 0; exp_cnt = 16'd0; prev_pop = 1'b0;
        rst = 1'b1; head_valid = 1'b0; head_element = {DW{1'b0}};
        cdb_valid = 1'b0; cdb_tag = 32'd0; cdb_data = 32'd0;
        branch = 1'b0; branch_tag = 32'd0; fu_ready = 1'b0;

        vt[0] = '{32'd5, 1'b1, 32'h11, 1'b1, 32'h22, -1, 32'd0, 32'd0, 32'h11, 32'h22};
        vt[1] = '{32'd6, 1'b1, 32'h33, 1'b0, 32'h7, 3, 32'h7, 32'hABCD, 32'h33, 32'hABCD};
        vt[2] = '{32'd7, 1'b0, 32'h8, 1'b1, 32'h44, 0, 32'h8, 32'hDEAD, 32'hDEAD, 32'h44};
        vt[3] = '{32'h8000_0000, 1'b0, 32'h3, 1'b0, 32'h3, 2, 32'h3, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
        vt[4] = '{32'hFFFF_FFFF, 1'b0, 32'h10, 1'b1, 32'h55, 1, 32'h10, 32'h0, 32'h0, 32'h55};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pop", pop, 0);
        chk("rst_fu_valid", fu_valid, 0);
        chk("rst_fu_entry", fu_entry, 0);
        chk("rst_busy", busy, 0);
        chk("rst_issue_count", issue_count, 0);

        // Table vectors, FU always ready
        fu_ready = 1'b1;
        for (int i = 0; i < 5; i++) run_vec(vt[i], i);
        fu_ready = 1'b0;

        // Flush of an entry waiting in ISSUE, equal tag kills
        @(posedge clk); #1;
        head_valid = 1'b1; head_element = mk(32'd9, 1'b1, 32'h1, 1'b1, 32'h2);
        @(posedge clk); #1; head_valid = 1'b0;
        @(posedge clk); #1;
        branch = 1'b1; branch_tag = 32'd9; fu_ready = 1'b1;
        @(negedge clk);
        chk("kill_pre_fu_valid", fu_valid, 1);
        @(posedge clk); #1; branch = 1'b0; fu_ready = 1'b0;
        @(negedge clk);
        chk("kill_fu_valid", fu_valid, 0);
        chk("kill_busy", busy, 0);
        chk("kill_issue_count", issue_count, exp_cnt);

        // Branch with a higher threshold leaves the entry in place
        @(posedge clk); #1;
        head_valid = 1'b1; head_element = mk(32'd9, 1'b1, 32'h5, 1'b1, 32'h6);
        exp_q.push_back(mk(32'd9, 1'b1, 32'h5, 1'b1, 32'h6));
        @(posedge clk); #1; head_valid = 1'b0;
        @(posedge clk); #1;
        branch = 1'b1; branch_tag = 32'd10;
        @(posedge clk); #1; branch = 1'b0;
        @(negedge clk);
        chk("keep_fu_valid", fu_valid, 1);
        chk("keep_fu_entry", fu_entry, mk(32'd9, 1'b1, 32'h5, 1'b1, 32'h6));
        @(posedge clk); #1; fu_ready = 1'b1;
        @(posedge clk); #1; fu_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        chk("keep_issue_count", issue_count, exp_cnt);
        chk("keep_idle_fu_valid", fu_valid, 0);

        // Back-to-back ready heads
        fu_ready = 1'b1;
        @(posedge clk); #1;
        head_valid = 1'b1; head_element = mk(32'h20, 1'b1, 32'hA1, 1'b1, 32'hA2);
        exp_q.push_back(mk(32'h20, 1'b1, 32'hA1, 1'b1, 32'hA2));
        @(posedge clk); #1;
        head_element = mk(32'h21, 1'b1, 32'hB1, 1'b1, 32'hB2);
        exp_q.push_back(mk(32'h21, 1'b1, 32'hB1, 1'b1, 32'hB2));
        @(negedge clk); chk("b2b_pop1", pop, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("b2b_nopop_issue", pop, 0); chk("b2b_fu_valid_a", fu_valid, 1);
        @(posedge clk); #1; head_valid = 1'b0;
        @(negedge clk); chk("b2b_pop2", pop, 1); chk("b2b_busy", busy, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("b2b_nopop_b", pop, 0); chk("b2b_fu_valid_b", fu_valid, 1);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd2;
        @(negedge clk); chk("b2b_issue_count", issue_count, exp_cnt); chk("b2b_idle", busy, 0);

        // Handshake counts but the killed next head is not captured
        @(posedge clk); #1;
        head_valid = 1'b1; head_element = mk(32'd4, 1'b1, 32'hC1, 1'b1, 32'hC2);
        exp_q.push_back(mk(32'd4, 1'b1, 32'hC1, 1'b1, 32'hC2));
        @(posedge clk); #1; head_valid = 1'b0;
        @(posedge clk); #1;
        head_valid = 1'b1; head_element = mk(32'd50, 1'b1, 32'hD1, 1'b1, 32'hD2);
        branch = 1'b1; branch_tag = 32'd30;
        @(posedge clk); #1; head_valid = 1'b0; branch = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        chk("hkill_pop", pop, 0);
        chk("hkill_busy", busy, 0);
        chk("hkill_issue_count", issue_count, exp_cnt);

        // Branch in IDLE blocks the capture
        @(posedge clk); #1;
        head_valid = 1'b1; head_element = mk(32'd20, 1'b1, 32'h1, 1'b1, 32'h1);
        branch = 1'b1; branch_tag = 32'd15;
        @(posedge clk); #1; head_valid = 1'b0; branch = 1'b0;
        @(negedge clk);
        chk("idle_kill_pop", pop, 0);
        chk("idle_kill_busy", busy, 0);

        // Reset while waiting on an operand
        @(posedge clk); #1;
        head_valid = 1'b1; head_element = mk(32'd3, 1'b1, 32'h1, 1'b0, 32'h99);
        @(posedge clk); #1; head_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        exp_cnt = 16'd0;
        @(negedge clk);
        chk("mid_rst_pop", pop, 0);
        chk("mid_rst_fu_valid", fu_valid, 0);
        chk("mid_rst_fu_entry", fu_entry, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_issue_count", issue_count, 0);

        // Counter wrap: preload the count, then one more handshake
        @(negedge clk);
        force dut.r_issue_count = 16'hFFFF;
        #1 release dut.r_issue_count;
        exp_cnt = 16'hFFFF;
        fu_ready = 1'b1;
        run_vec(vt[0], 9);
        fu_ready = 1'b0;

        chk("scoreboard_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
